register_input: RTL

- Input-port register for the 8-bit single-stage RISC core; the receive-side counterpart of the output-port register.
- Accepts bytes from an external device over a 4-phase strobe/ack handshake and buffers them in a small FIFO.
- The core consumes bytes when its ALU result equals the read code.
- Sits between the external pins and the core's register-file write mux.

---
 rtl/regin_pkg.sv | 12 +
 rtl/regin_fifo.sv | 50 +++++
 rtl/register_input.sv | 80 ++++++++
 3 files changed

// File: rtl/regin_pkg.sv
// Shared definitions for the input-port register: FSM states, port access codes, default depth.
package regin_pkg;
    localparam int         REGIN_DEPTH     = 4;
    localparam logic [7:0] PORT_WRITE_CODE = 8'hFF;
    localparam logic [7:0] PORT_READ_CODE  = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } regin_state_t;
endpackage

// File: rtl/regin_fifo.sv
// Small power-of-two FIFO; head reads as zero while empty so the core's write mux sees a clean value.
module regin_fifo #(
    parameter int Psize = 8,
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Psize-1:0]         wdata,
    output logic [Psize-1:0]         head,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Psize-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/register_input.sv
// Input-port register: 4-phase strobe/ack receiver feeding a FIFO popped by ALURes==ReadCode.
// Optional macro REGIN_SYNC_EN adds a 2-flop synchroniser on InStrobe.
module register_input
    import regin_pkg::*;
#(
    parameter int               Psize    = 8,
    parameter int               Depth    = REGIN_DEPTH,
    parameter logic [Psize-1:0] ReadCode = Psize'(PORT_READ_CODE)
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [Psize-1:0]       InData,
    input  logic                   InStrobe,
    output logic                   InAck,
    input  logic [Psize-1:0]       ALURes,
    output logic [Psize-1:0]       RegOut,
    output logic                   DataValid,
    output logic [$clog2(Depth):0] Count
);
    regin_state_t state, state_nxt;
    logic         s, push, pop, full, empty;

`ifdef REGIN_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (Reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], InStrobe};
    end
    assign s = sync_q[1];
`else
    assign s = InStrobe;
`endif

    assign pop       = (ALURes == ReadCode);
    assign DataValid = !empty;

    // Full test uses pre-edge occupancy, so a same-cycle pop never unblocks a push.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: if (s) begin
                if (!full) begin
                    push      = 1'b1;
                    state_nxt = ACK;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: if (!full) begin
                push      = 1'b1;
                state_nxt = ACK;
            end
            ACK:  if (!s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            InAck <= 1'b0;
        end else begin
            state <= state_nxt;
            InAck <= (state_nxt == ACK);
        end
    end

    regin_fifo #(.Psize(Psize), .Depth(Depth)) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (InData),
        .head  (RegOut),
        .count (Count),
        .full  (full),
        .empty (empty)
    );
endmodule
